// File: rtl/nios1_memtest_master.sv
`default_nettype none
// ============================================================================
//  Module      : nios1_memtest_master
//  Description : Avalon-MM memory test master for a single-port on-chip RAM
//                (read latency 1, no waitrequest). Writes an incrementing
//                pattern over a wrapping address window, reads it back,
//                counts mismatches and records the first failing address.
//  Revision    : 1.0 - initial release
// ============================================================================
module nios1_memtest_master #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       word_count,
    input  logic [DATA_W-1:0]     seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_W:0]       err_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic [ADDR_W-1:0]     m_address,
    output logic [DATA_W/8-1:0]   m_byteenable,
    output logic                  m_chipselect,
    output logic                  m_write,
    output logic [DATA_W-1:0]     m_writedata,
    input  logic [DATA_W-1:0]     m_readdata,
    output logic                  m_clken
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Largest testable window: every word of the memory exactly once.
    localparam logic [ADDR_W:0]     c_MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [DATA_W/8-1:0] c_BE_ALL    = '1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic [ADDR_W:0]     k_q, k_d;
    logic                rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0]   rd_off_q, rd_off_d;
    logic [ADDR_W:0]     err_q, err_d;
    logic [ADDR_W-1:0]   ferr_q, ferr_d;
    logic                pass_q, pass_d;

    logic                w_k_last;
    logic [ADDR_W-1:0]   w_cur_addr;
    logic [DATA_W-1:0]   w_cur_pat;
    logic [ADDR_W-1:0]   w_exp_addr;
    logic [DATA_W-1:0]   w_exp_pat;
    logic                w_mismatch;

    // Offset k maps to a wrapping address and a wrapping data pattern; the
    // read-back check uses the offset that was presented one cycle earlier.
    assign w_k_last   = (k_q == (n_q - 1'b1));
    assign w_cur_addr = base_q + k_q[ADDR_W-1:0];
    assign w_cur_pat  = seed_q + DATA_W'(k_q);
    assign w_exp_addr = base_q + rd_off_q;
    assign w_exp_pat  = seed_q + DATA_W'(rd_off_q);
    assign w_mismatch = rd_valid_q && (m_readdata != w_exp_pat);

    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;
    assign m_clken        = reset_n;

    // State and datapath registers; reset aborts any test in progress.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            seed_q     <= '0;
            n_q        <= '0;
            k_q        <= '0;
            rd_valid_q <= 1'b0;
            rd_off_q   <= '0;
            err_q      <= '0;
            ferr_q     <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            seed_q     <= seed_d;
            n_q        <= n_d;
            k_q        <= k_d;
            rd_valid_q <= rd_valid_d;
            rd_off_q   <= rd_off_d;
            err_q      <= err_d;
            ferr_q     <= ferr_d;
            pass_q     <= pass_d;
        end
    end

    // Next-state, result bookkeeping and Avalon-MM bus drive.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        seed_d       = seed_q;
        n_d          = n_q;
        k_d          = k_q;
        rd_valid_d   = (state_q == S_READ);
        rd_off_d     = k_q[ADDR_W-1:0];
        err_d        = err_q;
        ferr_d       = ferr_q;
        pass_d       = pass_q;
        m_address    = '0;
        m_byteenable = '0;
        m_chipselect = 1'b0;
        m_write      = 1'b0;
        m_writedata  = '0;

        // Read data returns one cycle after its address (READ 2..N, DRAIN).
        if (w_mismatch) begin
            err_d = err_q + 1'b1;
            if (err_q == '0) begin
                ferr_d = w_exp_addr;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d = base_addr;
                    seed_d = seed;
                    n_d    = (word_count > c_MAX_WORDS) ? c_MAX_WORDS : word_count;
                    k_d    = '0;
                    err_d  = '0;
                    ferr_d = '0;
                    // An empty test has nothing to mismatch, so it passes.
                    pass_d  = (word_count == '0);
                    state_d = (word_count == '0) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_byteenable = c_BE_ALL;
                m_address    = w_cur_addr;
                m_writedata  = w_cur_pat;
                if (w_k_last) begin
                    k_d     = '0;
                    state_d = S_READ;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_READ: begin
                m_chipselect = 1'b1;
                m_byteenable = c_BE_ALL;
                m_address    = w_cur_addr;
                if (w_k_last) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // err_d already includes the final read-back comparison.
                pass_d  = (err_d == '0);
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_nios1_memtest_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nios1_memtest_master
//  Description : Self-checking bench for nios1_memtest_master with a
//                latency-1 RAM model, fault injection and a scoreboard of
//                expected writes and expected test results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nios1_memtest_master;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_count = '0;
    logic [DW-1:0] seed = '0;
    logic          busy, done, pass;
    logic [AW:0]   err_count;
    logic [AW-1:0] first_err_addr;
    logic [AW-1:0] m_address;
    logic [BW-1:0] m_byteenable;
    logic          m_chipselect, m_write, m_clken;
    logic [DW-1:0] m_writedata;
    logic [DW-1:0] m_readdata;

    nios1_memtest_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .m_address      (m_address),
        .m_byteenable   (m_byteenable),
        .m_chipselect   (m_chipselect),
        .m_write        (m_write),
        .m_writedata    (m_writedata),
        .m_readdata     (m_readdata),
        .m_clken        (m_clken)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // RAM model: 0 = clean, 1 = bit 3 of address 5 stuck at 1, 2 = bit 0 flipped everywhere
    int            fault_mode = 0;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ram_q = '0;
    logic [AW-1:0] ram_addr_q = '0;

    function automatic logic [DW-1:0] corrupt(input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (fault_mode == 1 && a == AW'(5)) return d | DW'(8);
        if (fault_mode == 2) return d ^ DW'(1);
        return d;
    endfunction

    always @(posedge clk) begin
        if (m_clken && m_chipselect) begin
            if (m_write) mem[m_address] <= m_writedata;
            else begin
                ram_q      <= mem[m_address];
                ram_addr_q <= m_address;
            end
        end
    end
    assign m_readdata = corrupt(ram_addr_q, ram_q);

    // Scoreboard
    typedef struct {
        logic [AW:0]   err;
        logic [AW-1:0] faddr;
        logic          pss;
    } res_t;

    logic [AW-1:0] q_addr [$];
    logic [DW-1:0] q_data [$];
    res_t          q_res  [$];
    bit            sb_en  = 1'b1;
    int            rd_cnt = 0;
    logic [AW-1:0] mon_a;
    logic [DW-1:0] mon_d;
    res_t          mon_r;

    // Pops expected writes/results as the DUT produces them.
    always @(negedge clk) begin
        if (sb_en) begin
            if (m_chipselect) begin
                checks++;
                if (m_byteenable !== {BW{1'b1}}) begin
                    errors++;
                    $display("FAIL byteenable: got %h want %h", m_byteenable, {BW{1'b1}});
                end
            end
            if (m_chipselect && m_write) begin
                checks++;
                if (q_addr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr %h data %h", m_address, m_writedata);
                end else begin
                    mon_a = q_addr.pop_front();
                    mon_d = q_data.pop_front();
                    if (m_address !== mon_a || m_writedata !== mon_d) begin
                        errors++;
                        $display("FAIL write: got addr %h data %h want addr %h data %h",
                                 m_address, m_writedata, mon_a, mon_d);
                    end
                end
            end
            if (m_chipselect && !m_write) rd_cnt++;
            if (done) begin
                checks++;
                if (q_res.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: err_count %0d", err_count);
                end else begin
                    mon_r = q_res.pop_front();
                    if (err_count !== mon_r.err || first_err_addr !== mon_r.faddr || pass !== mon_r.pss) begin
                        errors++;
                        $display("FAIL result: got err %0d first %h pass %b want err %0d first %h pass %b",
                                 err_count, first_err_addr, pass, mon_r.err, mon_r.faddr, mon_r.pss);
                    end
                end
            end
        end
    end

    // Runs one test: predicts writes/results, starts the DUT, checks timing and hold.
    task automatic run_test(input logic [AW-1:0] b, input logic [AW:0] wc,
                            input logic [DW-1:0] s, input bit immediate, input int ign_at);
        int            n, lat, busy_cyc, exp_lat;
        bit            got_done;
        logic [AW:0]   e_err;
        logic [AW-1:0] e_fa, a;
        logic [DW-1:0] d;
        n     = (wc > 13'd4096) ? 4096 : int'(wc);
        e_err = '0;
        e_fa  = '0;
        for (int k = 0; k < n; k++) begin
            a = b + AW'(k);
            d = s + DW'(k);
            q_addr.push_back(a);
            q_data.push_back(d);
            if (corrupt(a, d) !== d) begin
                if (e_err == '0) e_fa = a;
                e_err = e_err + 1'b1;
            end
        end
        q_res.push_back('{e_err, e_fa, (e_err == '0)});
        if (!immediate) begin
            @(posedge clk); #1;
        end
        rd_cnt     = 0;
        base_addr  = b;
        word_count = wc;
        seed       = s;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        base_addr  = ~b;
        word_count = wc + 13'd3;
        seed       = ~s;
        lat = 0; busy_cyc = 0; got_done = 0;
        exp_lat = (n == 0) ? 1 : 2 * n + 2;
        while (!got_done && lat < exp_lat + 20) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cyc++;
            if (done) got_done = 1;
            if (lat == ign_at) begin
                start      = 1'b1;
                word_count = 13'd1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (!got_done || lat != exp_lat) begin
            errors++;
            $display("FAIL done_latency: got %0d (done seen %0d) want %0d", lat, got_done, exp_lat);
        end
        checks++;
        if (busy_cyc != exp_lat) begin
            errors++;
            $display("FAIL busy_cycles: got %0d want %0d", busy_cyc, exp_lat);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL after_done: busy %b done %b want 0 0", busy, done);
        end
        checks++;
        if (err_count !== e_err || first_err_addr !== e_fa || pass !== (e_err == '0)) begin
            errors++;
            $display("FAIL hold: got err %0d first %h pass %b want err %0d first %h pass %b",
                     err_count, first_err_addr, pass, e_err, e_fa, (e_err == '0));
        end
        checks++;
        if (rd_cnt != n || q_addr.size() != 0 || q_res.size() != 0) begin
            errors++;
            $display("FAIL traffic: reads %0d want %0d, writes left %0d, results left %0d",
                     rd_cnt, n, q_addr.size(), q_res.size());
        end
        q_addr.delete();
        q_data.delete();
        q_res.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, pass, err_count, first_err_addr, m_chipselect, m_write,
             m_address, m_writedata, m_byteenable, m_clken} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy %b done %b pass %b err %h first %h cs %b wr %b addr %h wd %h be %h clken %b want all 0",
                     busy, done, pass, err_count, first_err_addr, m_chipselect, m_write,
                     m_address, m_writedata, m_byteenable, m_clken);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        checks++;
        if (m_clken !== 1'b1) begin
            errors++;
            $display("FAIL clken: got %b want 1", m_clken);
        end
        run_test(AW'(12'h040), 13'd2, 16'h00AA, 1'b1, 0);
    endtask

    task automatic test_basic();
        run_test(AW'(12'h000), 13'd4, 16'h1000, 1'b0, 0);
    endtask

    task automatic test_wrap();
        run_test(AW'(12'hFFE), 13'd4, 16'hFFFF, 1'b0, 0);
    endtask

    task automatic test_fault();
        fault_mode = 1;
        run_test(AW'(12'h000), 13'd8, 16'h0000, 1'b0, 0);
        fault_mode = 0;
        run_test(AW'(12'h000), 13'd8, 16'h0000, 1'b0, 0);
    endtask

    task automatic test_zero();
        run_test(AW'(12'h123), 13'd0, 16'h5555, 1'b0, 0);
    endtask

    task automatic test_ignore();
        // READ spans latency 9..16 for N=8; pulse start inside it
        run_test(AW'(12'h200), 13'd8, 16'hABCD, 1'b0, 10);
    endtask

    task automatic test_abort();
        sb_en = 1'b0;
        @(posedge clk); #1;
        base_addr  = AW'(12'h100);
        word_count = 13'd8;
        seed       = 16'h0055;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (m_chipselect !== 1'b1 || m_write !== 1'b1 || m_address !== AW'(12'h102)) begin
            errors++;
            $display("FAIL abort_pre: cs %b wr %b addr %h want 1 1 102", m_chipselect, m_write, m_address);
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (m_chipselect !== 1'b0 || m_write !== 1'b0 || busy !== 1'b0 || m_clken !== 1'b0) begin
            errors++;
            $display("FAIL abort_post: cs %b wr %b busy %b clken %b want 0 0 0 0",
                     m_chipselect, m_write, busy, m_clken);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle: done %b busy %b want 0 0", done, busy);
            end
        end
        sb_en = 1'b1;
        run_test(AW'(12'h100), 13'd8, 16'h0055, 1'b0, 0);
    endtask

    task automatic test_full();
        // Every read corrupted over the whole memory; count is clamped to 4096
        fault_mode = 2;
        run_test(AW'(12'h123), 13'h1FFF, 16'h7777, 1'b0, 0);
        fault_mode = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_fault();
        test_zero();
        test_ignore();
        test_abort();
        test_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/nios1_memtest_master.md
NIOS1_MEMTEST_MASTER -- requirements
Module: nios1_memtest_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: word address width of the target memory.
REQ-002 SHALL have parameter DATA_W, default 16: data width of the target memory; byteenable width is DATA_W/8.
REQ-003 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: single-cycle test request.
REQ-006 SHALL have port base_addr, input, ADDR_W: first word address.
REQ-007 SHALL have port word_count, input, ADDR_W+1: number of words to test.
REQ-008 SHALL have port seed, input, DATA_W: pattern seed.
REQ-009 SHALL have port busy, output, 1: test in progress.
REQ-010 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port pass, output, 1: last test had zero mismatches.
REQ-012 SHALL have port err_count, output, ADDR_W+1: mismatch count of last test.
REQ-013 SHALL have port first_err_addr, output, ADDR_W: address of first mismatch.
REQ-014 SHALL have Avalon-MM master ports m_address (out, ADDR_W), m_byteenable (out, DATA_W/8), m_chipselect (out, 1), m_write (out, 1), m_writedata (out, DATA_W), m_readdata (in, DATA_W) and m_clken (out, 1), connecting to a single-port on-chip RAM slave with fixed read latency 1 and no waitrequest.

Function
REQ-015 SHALL implement states IDLE, WRITE, READ, DRAIN, DONE.
REQ-016 In IDLE, start=1 SHALL latch base_addr, seed and N=min(word_count, 2^ADDR_W); the next state is WRITE if N>0, otherwise DONE.
REQ-017 start SHALL be ignored in every state except IDLE.
REQ-018 Word offset k (0..N-1) SHALL map to address (base+k) mod 2^ADDR_W; wrap-around past the top address is legal.
REQ-019 The pattern for offset k SHALL be (seed+k) mod 2^DATA_W.
REQ-020 WRITE SHALL last exactly N cycles, with one write per cycle: m_chipselect=1, m_write=1, m_byteenable all ones, and m_address/m_writedata set for offset k.
REQ-021 READ SHALL last exactly N cycles, with one read per cycle: m_chipselect=1, m_write=0, m_byteenable all ones.
REQ-022 m_readdata SHALL be sampled in the cycle after the read address is presented (READ cycles 2..N, then DRAIN) and compared against the expected pattern of the previous cycle's offset.
REQ-023 DRAIN SHALL last 1 cycle with m_chipselect=0 and SHALL perform the final comparison.
REQ-024 Each mismatch SHALL increment err_count by 1; the first mismatch of a test SHALL capture its address into first_err_addr.
REQ-025 DONE SHALL last 1 cycle with done=1 and pass=(err_count==0), then return to IDLE.
REQ-026 busy SHALL be 1 in WRITE, READ, DRAIN and DONE; total busy duration SHALL be 2N+2 cycles for N>0 and 1 cycle for N=0.
REQ-027 Outside WRITE and READ, m_chipselect and m_write SHALL be 0.
REQ-028 m_clken SHALL be 1 whenever reset_n=1.
REQ-029 err_count and first_err_addr SHALL be cleared on accepted start and SHALL hold from DONE until the next accepted start; pass SHALL also hold until then.
REQ-030 With N=2^ADDR_W, err_count SHALL reach 2^ADDR_W without overflow.

Reset
REQ-031 With reset_n=0 at a clock edge, the state SHALL become IDLE and busy, done, pass, err_count, first_err_addr, m_chipselect, m_write, m_address, m_writedata and m_byteenable SHALL all become 0; m_clken SHALL be 0 while reset_n=0.
REQ-032 Reset during any active state SHALL abort the test with no done pulse; the master SHALL be ready for start on the first cycle after reset_n returns to 1.

Verification
REQ-033 Reset: hold reset_n=0 for 2 cycles -> all outputs 0 and no bus activity; start in the first cycle after release is accepted.
REQ-034 Basic test with RAM model: base=0x000, count=4, seed=0x1000, start at cycle T -> writes 0x1000..0x1003 to addresses 0..3 in T+1..T+4, reads in T+5..T+8, done=1 at T+10, pass=1, err_count=0.
REQ-035 Wrap-around: base=0xFFE, count=4, seed=0xFFFF -> write addresses 0xFFE, 0xFFF, 0x000, 0x001 with data 0xFFFF, 0x0000, 0x0001, 0x0002; pass=1.
REQ-036 Fault injection: RAM model forces bit 3 of address 5 to 1, base=0, count=8, seed=0 -> err_count=1, first_err_addr=5, pass=0; a second start with the fault removed -> err_count=0, pass=1.
REQ-037 Zero count: count=0 -> done=1 on the cycle after start, busy high for 1 cycle, pass=1, m_chipselect never asserted.
REQ-038 Abort and ignore: start pulsed during READ is ignored with no effect on the count; reset_n=0 at WRITE cycle 3 of count=8 -> m_chipselect=0 after that edge, no done pulse, next start runs the full 18-cycle test.
